// File: rtl/ext_mem_slave_if.sv
// Master-side memory request bus between the HLS `main` port and ext_mem_slave.
interface ext_mem_slave_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    // Handshake: the master raises exactly one of Mout_oe_ram / Mout_we_ram
    // and holds it with stable address/data until M_DataRdy is seen high for
    // one cycle; it drops the request in the following cycle. A request still
    // present after that cycle is a new access. Dropping early aborts it.
    logic              Mout_oe_ram;
    logic              Mout_we_ram;
    logic [ADDR_W-1:0] Mout_addr_ram;
    logic [DATA_W-1:0] Mout_Wdata_ram;
    logic [3:0]        Mout_data_ram_size;
    logic [DATA_W-1:0] M_Rdata_ram;
    logic              M_DataRdy;

    modport master (
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        input  M_Rdata_ram, M_DataRdy
    );

    modport slave (
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        output M_Rdata_ram, M_DataRdy
    );
endinterface

// File: rtl/ext_mem_slave.sv
// Fixed-latency off-chip memory responder for the HLS `main` master port.
// Optional preload port enabled by defining EXT_MEM_PRELOAD_EN.
module ext_mem_slave #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MEMSIZE   = 16,
    parameter int RD_DELAY  = 2,
    parameter int WR_DELAY  = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    ext_mem_slave_if.slave             bus,
`ifdef EXT_MEM_PRELOAD_EN
    input  logic                       init_we,
    input  logic [$clog2(MEMSIZE)-1:0] init_addr,
    input  logic [DATA_W-1:0]          init_data,
`endif
    output logic                       err_both,
    output logic [1:0]                 fsm_state
);
    localparam int IDX_W     = $clog2(MEMSIZE);
    localparam int MAX_DELAY = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
    localparam int CNT_W     = $clog2(MAX_DELAY + 1);
    localparam logic [ADDR_W:0]  LO      = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]  HI      = (ADDR_W+1)'(BASE_ADDR + MEMSIZE);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_DELAY - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_DELAY - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ACK} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdy_q, rdy_d;
    logic              err_q;

`ifdef EXT_MEM_PRELOAD_EN
    logic [DATA_W-1:0] mem [MEMSIZE];
`else
    logic [DATA_W-1:0] mem [MEMSIZE] = '{default: '0};
`endif

    logic [ADDR_W:0]   addr_ext;
    logic              in_range;
    logic [IDX_W-1:0]  req_idx;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] merged;
    logic              do_write;

    assign addr_ext = {1'b0, bus.Mout_addr_ram};
    assign in_range = (addr_ext >= LO) && (addr_ext < HI);
    assign req_idx  = IDX_W'(addr_ext - LO);

    // Size is in bits; anything covering the whole lane writes the full word.
    always_comb begin
        mask = '1;
        if (32'(bus.Mout_data_ram_size) < DATA_W)
            mask = DATA_W'((32'd1 << bus.Mout_data_ram_size) - 32'd1);
    end

    assign merged = (bus.Mout_Wdata_ram & mask) | (mem[req_idx] & ~mask);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rdata_d  = '0;
        rdy_d    = 1'b0;
        do_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Mout_oe_ram && !bus.Mout_we_ram && in_range) begin
                    idx_d = req_idx;
                    if (RD_DELAY == 1) begin
                        rdata_d = mem[req_idx];
                        rdy_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = RD_WAIT;
                    end
                end else if (bus.Mout_we_ram && !bus.Mout_oe_ram && in_range) begin
                    idx_d    = req_idx;
                    do_write = 1'b1;
                    if (WR_DELAY == 1) begin
                        rdata_d = merged;
                        rdy_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (!bus.Mout_oe_ram) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == RD_LAST) begin
                    rdata_d = mem[idx_q];
                    rdy_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_WAIT: begin
                // The write already landed at accept; an abort leaves it in place.
                if (!bus.Mout_we_ram) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == WR_LAST) begin
                    rdata_d = mem[idx_q];
                    rdy_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_q | (bus.Mout_oe_ram & bus.Mout_we_ram);
        end
    end

    // Init write is last so it wins a same-index collision with the master.
    always_ff @(posedge clock) begin
        if (do_write && !reset)
            mem[req_idx] <= merged;
`ifdef EXT_MEM_PRELOAD_EN
        if (init_we)
            mem[init_addr] <= init_data;
`endif
    end

    assign bus.M_Rdata_ram = rdata_q;
    assign bus.M_DataRdy   = rdy_q;
    assign err_both        = err_q;
    assign fsm_state       = state_q;
endmodule

// File: tb/tb_ext_mem_slave.sv
// Directed bench for ext_mem_slave: instance A (BASE 0x40, RD 2, WR 1) and
// instance B (BASE 0, RD 4, WR 2) share clock and reset.
module tb_ext_mem_slave;
    logic       clock;
    logic       reset;
    logic       err_a, err_b;
    logic [1:0] st_a, st_b;
    int         checks;
    int         errors;

    ext_mem_slave_if #(.ADDR_W(13), .DATA_W(8)) bus_a ();
    ext_mem_slave_if #(.ADDR_W(13), .DATA_W(8)) bus_b ();

    ext_mem_slave #(.ADDR_W(13), .DATA_W(8), .BASE_ADDR(64), .MEMSIZE(16),
                    .RD_DELAY(2), .WR_DELAY(1)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a),
`ifdef EXT_MEM_PRELOAD_EN
        .init_we(1'b0), .init_addr(4'd0), .init_data(8'd0),
`endif
        .err_both(err_a), .fsm_state(st_a)
    );

    ext_mem_slave #(.ADDR_W(13), .DATA_W(8), .BASE_ADDR(0), .MEMSIZE(16),
                    .RD_DELAY(4), .WR_DELAY(2)) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b),
`ifdef EXT_MEM_PRELOAD_EN
        .init_we(1'b0), .init_addr(4'd0), .init_data(8'd0),
`endif
        .err_both(err_b), .fsm_state(st_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Driver: returns ack latency in cycles after the request cycle, -1 if none.
    task automatic write_a(input logic [12:0] a, input logic [7:0] d, input logic [3:0] s,
                           output int lat);
        lat = -1;
        @(negedge clock);
        bus_a.Mout_we_ram = 1'b1;
        bus_a.Mout_addr_ram = a;
        bus_a.Mout_Wdata_ram = d;
        bus_a.Mout_data_ram_size = s;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (bus_a.M_DataRdy) begin
                lat = k;
                break;
            end
        end
        bus_a.Mout_we_ram = 1'b0;
        @(negedge clock);
    endtask

    task automatic read_a(input logic [12:0] a, output logic [7:0] d, output int lat);
        lat = -1;
        d = 8'h00;
        @(negedge clock);
        bus_a.Mout_oe_ram = 1'b1;
        bus_a.Mout_addr_ram = a;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (bus_a.M_DataRdy) begin
                lat = k;
                d = bus_a.M_Rdata_ram;
                break;
            end
        end
        bus_a.Mout_oe_ram = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (bus_a.M_DataRdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", bus_a.M_DataRdy); end
        checks++; if (bus_a.M_Rdata_ram !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", bus_a.M_Rdata_ram); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_a); end
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st_a); end
        checks++; if (bus_b.M_DataRdy !== 1'b0) begin errors++; $display("FAIL reset_rdy_b got %b exp 0", bus_b.M_DataRdy); end
        apply_reset();
    endtask

    task automatic test_read_timing();
        int lat;
        write_a(13'h43, 8'hA5, 4'd8, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL wr_lat got %0d exp 1", lat); end
        @(negedge clock);
        bus_a.Mout_oe_ram = 1'b1;
        bus_a.Mout_addr_ram = 13'h43;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) @(negedge clock);
            checks++; if (bus_a.M_DataRdy !== (k == 2)) begin errors++; $display("FAIL rd_rdy c%0d got %b exp %b", k, bus_a.M_DataRdy, (k == 2)); end
            checks++; if (bus_a.M_Rdata_ram !== ((k == 2) ? 8'hA5 : 8'h00)) begin errors++; $display("FAIL rd_data c%0d got %h", k, bus_a.M_Rdata_ram); end
            if (k == 2) bus_a.Mout_oe_ram = 1'b0;
        end
    endtask

    task automatic test_write_mask();
        int lat;
        logic [7:0] d;
        logic [3:0]  sz   [5] = '{4'd8, 4'd4, 4'd0, 4'd15, 4'd3};
        logic [7:0]  wd   [5] = '{8'h30, 8'hFF, 8'h00, 8'h5A, 8'h00};
        logic [7:0]  expd [5] = '{8'h30, 8'h3F, 8'h3F, 8'h5A, 8'h58};
        for (int i = 0; i < 5; i++) begin
            write_a(13'h45, wd[i], sz[i], lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL mask_wr_lat%0d got %0d exp 1", i, lat); end
            read_a(13'h45, d, lat);
            checks++; if (lat !== 2) begin errors++; $display("FAIL mask_rd_lat%0d got %0d exp 2", i, lat); end
            checks++; if (d !== expd[i]) begin errors++; $display("FAIL mask_data%0d got %h exp %h", i, d, expd[i]); end
        end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [7:0] d;
        @(negedge clock);
        bus_a.Mout_oe_ram = 1'b1;
        bus_a.Mout_addr_ram = 13'h50;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clock);
            checks++; if (bus_a.M_DataRdy !== 1'b0) begin errors++; $display("FAIL oor_rdy c%0d got %b exp 0", k, bus_a.M_DataRdy); end
            checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL oor_state c%0d got %0d exp 0", k, st_a); end
        end
        bus_a.Mout_oe_ram = 1'b0;
        write_a(13'h3F, 8'hEE, 4'd8, lat);
        checks++; if (lat !== -1) begin errors++; $display("FAIL oor_wr_ack got %0d exp -1", lat); end
        read_a(13'h4F, d, lat);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL oor_wr_effect got %h exp 00", d); end
    endtask

    task automatic test_err_both();
        int lat;
        logic [7:0] d;
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL err_pre got %b exp 0", err_a); end
        @(negedge clock);
        bus_a.Mout_oe_ram = 1'b1;
        bus_a.Mout_we_ram = 1'b1;
        bus_a.Mout_addr_ram = 13'h45;
        bus_a.Mout_Wdata_ram = 8'h00;
        bus_a.Mout_data_ram_size = 4'd8;
        @(negedge clock);
        bus_a.Mout_oe_ram = 1'b0;
        bus_a.Mout_we_ram = 1'b0;
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL err_state got %0d exp 0", st_a); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL err_sticky c%0d got %b exp 1", k, err_a); end
            checks++; if (bus_a.M_DataRdy !== 1'b0) begin errors++; $display("FAIL err_rdy c%0d got %b exp 0", k, bus_a.M_DataRdy); end
            @(negedge clock);
        end
        read_a(13'h45, d, lat);
        checks++; if (d !== 8'h58) begin errors++; $display("FAIL err_mem got %h exp 58", d); end
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL err_hold got %b exp 1", err_a); end
        apply_reset();
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err_a); end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        bus_a.Mout_oe_ram = 1'b1;
        bus_a.Mout_addr_ram = 13'h43;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clock);
            checks++; if (bus_a.M_DataRdy !== (k == 2 || k == 5)) begin errors++; $display("FAIL b2b_rdy c%0d got %b", k, bus_a.M_DataRdy); end
            if (k == 5) bus_a.Mout_oe_ram = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic test_abort();
        @(negedge clock);
        bus_b.Mout_we_ram = 1'b1;
        bus_b.Mout_addr_ram = 13'h002;
        bus_b.Mout_Wdata_ram = 8'h77;
        bus_b.Mout_data_ram_size = 4'd8;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) @(negedge clock);
            checks++; if (bus_b.M_DataRdy !== (k == 2)) begin errors++; $display("FAIL b_wr_rdy c%0d got %b", k, bus_b.M_DataRdy); end
            if (k == 2) bus_b.Mout_we_ram = 1'b0;
        end
        @(negedge clock);
        bus_b.Mout_oe_ram = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clock);
            checks++; if (bus_b.M_DataRdy !== (k == 7)) begin errors++; $display("FAIL abort_rdy c%0d got %b", k, bus_b.M_DataRdy); end
            if (k == 2) bus_b.Mout_oe_ram = 1'b0;
            if (k == 3) begin
                checks++; if (st_b !== 2'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", st_b); end
                bus_b.Mout_oe_ram = 1'b1;
            end
            if (k == 7) begin
                checks++; if (bus_b.M_Rdata_ram !== 8'h77) begin errors++; $display("FAIL abort_data got %h exp 77", bus_b.M_Rdata_ram); end
                bus_b.Mout_oe_ram = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [7:0] d;
        @(negedge clock);
        bus_a.Mout_oe_ram = 1'b1;
        bus_a.Mout_addr_ram = 13'h45;
        @(negedge clock);
        checks++; if (st_a !== 2'd1) begin errors++; $display("FAIL mid_pre_state got %0d exp 1", st_a); end
        reset = 1'b1;
        #1;
        checks++; if (st_a !== 2'd0) begin errors++; $display("FAIL mid_state got %0d exp 0", st_a); end
        checks++; if (bus_a.M_DataRdy !== 1'b0) begin errors++; $display("FAIL mid_rdy got %b exp 0", bus_a.M_DataRdy); end
        checks++; if (bus_a.M_Rdata_ram !== 8'h00) begin errors++; $display("FAIL mid_rdata got %h exp 00", bus_a.M_Rdata_ram); end
        bus_a.Mout_oe_ram = 1'b0;
        @(negedge clock);
        checks++; if (bus_a.M_DataRdy !== 1'b0) begin errors++; $display("FAIL mid_noack got %b exp 0", bus_a.M_DataRdy); end
        reset = 1'b0;
        @(negedge clock);
        read_a(13'h45, d, lat);
        checks++; if (d !== 8'h58 || lat !== 2) begin errors++; $display("FAIL mid_persist5 got %h/%0d exp 58/2", d, lat); end
        read_a(13'h43, d, lat);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL mid_persist3 got %h exp a5", d); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus_a.Mout_oe_ram = 1'b0;
        bus_a.Mout_we_ram = 1'b0;
        bus_a.Mout_addr_ram = '0;
        bus_a.Mout_Wdata_ram = '0;
        bus_a.Mout_data_ram_size = '0;
        bus_b.Mout_oe_ram = 1'b0;
        bus_b.Mout_we_ram = 1'b0;
        bus_b.Mout_addr_ram = '0;
        bus_b.Mout_Wdata_ram = '0;
        bus_b.Mout_data_ram_size = '0;
        test_reset();
        test_read_timing();
        test_write_mask();
        test_out_of_range();
        test_err_both();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
